tx_align_gen: RTL

//  Transmit-side companion to the linkin alignment logic. Drives the 36-bit

---
 rtl/link_align_pkg.sv | 22 ++
 rtl/tx_train_timer.sv | 39 +++
 rtl/tx_align_gen.sv | 103 ++++++++++
 3 files changed

// File: rtl/link_align_pkg.sv
// Shared link alignment definitions used by both the transmit pattern
// generator and the receive-side aligner.
package link_align_pkg;

    localparam int LANES  = 9;
    localparam int LANE_W = 4;
    localparam int WORD_W = LANES * LANE_W;

    // Sent LSB first, so it arrives on the wire as "1000".
    localparam logic [LANE_W-1:0] ALIGN_NIBBLE = 4'b0001;

    typedef enum logic [1:0] {
        ST_OFFLINE = 2'd0,
        ST_TRAIN   = 2'd1,
        ST_DATA    = 2'd2
    } link_state_e;

    function automatic logic [WORD_W-1:0] train_word();
        return {LANES{ALIGN_NIBBLE}};
    endfunction

endpackage

// File: rtl/tx_train_timer.sv
// Training duration counter: cleared on load, counts while enabled, tc marks
// the last pattern cycle (count == TRAIN_LEN-1).
module tx_train_timer #(
    parameter int TRAIN_LEN = 1024
) (
    input  logic txclock,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tc
);

    // One spare count so the increment on the exit cycle cannot wrap.
    localparam int CNT_W = $clog2(TRAIN_LEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TRAIN_LEN - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge txclock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == LAST);

endmodule

// File: rtl/tx_align_gen.sv
// Transmit-side alignment generator: sends the per-lane training nibble after
// lock or on request, otherwise forwards user data or the idle word.
//
//  state      | meaning
//  -----------+------------------------------------------------------
//  ST_OFFLINE | PLL not locked; txout held at zero
//  ST_TRAIN   | training pattern on every lane for TRAIN_LEN cycles
//  ST_DATA    | user data (or IDLE_WORD) forwarded, data_ready high
module tx_align_gen
    import link_align_pkg::*;
#(
    parameter int               TRAIN_LEN  = 1024,
    parameter bit               AUTO_TRAIN = 1'b1,
    parameter logic [WORD_W-1:0] IDLE_WORD = '0
) (
    input  logic              txclock,
    input  logic              reset,
    input  logic              tx_locked,
    input  logic              train_req,
    input  logic [WORD_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [WORD_W-1:0] txout,
    output logic              training,
    output logic              train_done
);

    link_state_e       state_q, state_d;
    logic              req_dly_q, req_dly_d;
    logic [WORD_W-1:0] txout_q, txout_d;
    logic              training_q, training_d;
    logic              train_done_q, train_done_d;

    logic req_edge;
    logic timer_load;
    logic timer_en;
    logic timer_tc;

    assign req_dly_d = train_req;
    assign req_edge  = train_req & ~req_dly_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFFLINE: if (tx_locked) state_d = AUTO_TRAIN ? ST_TRAIN : ST_DATA;
            ST_TRAIN:   if (timer_tc && !req_edge) state_d = ST_DATA;
            ST_DATA:    if (req_edge) state_d = ST_TRAIN;
            default:    state_d = ST_OFFLINE;
        endcase
        if (!tx_locked) begin
            state_d = ST_OFFLINE;
        end
    end

    // Outputs are registered from the next state so txout, training and
    // train_done all line up with the state they describe.
    always_comb begin
        txout_d = '0;
        case (state_d)
            ST_TRAIN: txout_d = train_word();
            ST_DATA:  txout_d = data_valid ? data_in : IDLE_WORD;
            default:  txout_d = '0;
        endcase
        training_d   = (state_d == ST_TRAIN);
        train_done_d = (state_q == ST_TRAIN) && (state_d == ST_DATA);
    end

    // A retrigger while training restarts the count like a fresh entry.
    assign timer_load = (state_d == ST_TRAIN) && ((state_q != ST_TRAIN) || req_edge);
    assign timer_en   = (state_q == ST_TRAIN);

    tx_train_timer #(
        .TRAIN_LEN(TRAIN_LEN)
    ) u_timer (
        .txclock(txclock),
        .reset  (reset),
        .load   (timer_load),
        .en     (timer_en),
        .tc     (timer_tc)
    );

    always_ff @(posedge txclock) begin
        if (reset) begin
            state_q      <= ST_OFFLINE;
            req_dly_q    <= 1'b0;
            txout_q      <= '0;
            training_q   <= 1'b0;
            train_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_dly_q    <= req_dly_d;
            txout_q      <= txout_d;
            training_q   <= training_d;
            train_done_q <= train_done_d;
        end
    end

    assign data_ready = (state_q == ST_DATA);
    assign txout      = txout_q;
    assign training   = training_q;
    assign train_done = train_done_q;

endmodule
